// File: rtl/retrosoc_rst_gen.sv
// Core reset sequencer: synchronises board reset, filters clock-wizard lock,
// holds the core in reset for a fixed window and records the last reset cause.
module retrosoc_rst_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILT   = 16,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
  output logic       rst_n_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_cnt_o
);

  localparam int unsigned CNT_MAX = (LOCK_FILT > HOLD_CYCLES) ? LOCK_FILT : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_PIN  = 2'b00,
    CAUSE_LOCK = 2'b01,
    CAUSE_SW   = 2'b10
  } cause_t;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_sync_n;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rst_n;
  cause_t                 r_cause;
  logic [7:0]             r_rst_cnt;
  logic [7:0]             w_rst_cnt_inc;

  // Assert asynchronously, release two edges after the pin goes high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_sync_n = r_rst_sync[1];

  always_ff @(posedge clk_i or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign w_lock_s      = r_lock_sync[SYNC_STAGES-1];
  assign w_rst_cnt_inc = (r_rst_cnt == 8'hFF) ? r_rst_cnt : r_rst_cnt + 8'd1;

  // r_rst_n is assigned alongside each transition so it tracks the next state.
  always_ff @(posedge clk_i or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_state   <= WAIT_LOCK;
      r_cnt     <= '0;
      r_rst_n   <= 1'b0;
      r_cause   <= CAUSE_PIN;
      r_rst_cnt <= '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_rst_n <= 1'b0;
          if (!w_lock_s) begin
            r_cnt <= '0;
          end else if (r_cnt == FILT_LAST) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!w_lock_s) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_rst_n   <= 1'b0;
            r_cause   <= CAUSE_LOCK;
            r_rst_cnt <= w_rst_cnt_inc;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_rst_n <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_rst_n <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= '0;
          if (!w_lock_s) begin
            r_state   <= WAIT_LOCK;
            r_rst_n   <= 1'b0;
            r_cause   <= CAUSE_LOCK;
            r_rst_cnt <= w_rst_cnt_inc;
          end else if (sw_rst_req_i) begin
            r_state   <= HOLD;
            r_rst_n   <= 1'b0;
            r_cause   <= CAUSE_SW;
            r_rst_cnt <= w_rst_cnt_inc;
          end else begin
            r_rst_n <= 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
          r_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o     = r_rst_n;
  assign rst_cause_o = r_cause;
  assign rst_cnt_o   = r_rst_cnt;

endmodule

// File: tb/tb_retrosoc_rst_gen.sv
// Scoreboard bench for retrosoc_rst_gen: a cycle-level behavioural model
// predicts every edge, a monitor compares, directed latency checks on top.
module tb_retrosoc_rst_gen;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LOCK_FILT   = 16;
  localparam int unsigned HOLD_CYCLES = 64;
  localparam int PH_WAIT = 0;
  localparam int PH_HOLD = 1;
  localparam int PH_RUN  = 2;

  logic       clk_i        = 1'b0;
  logic       rst_n_i      = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       sw_rst_req_i = 1'b0;
  logic       rst_n_o;
  logic [1:0] rst_cause_o;
  logic [7:0] rst_cnt_o;

  retrosoc_rst_gen #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_FILT  (LOCK_FILT),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .pll_locked_i(pll_locked_i),
    .sw_rst_req_i(sw_rst_req_i),
    .rst_n_o     (rst_n_o),
    .rst_cause_o (rst_cause_o),
    .rst_cnt_o   (rst_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       rstn;
    bit [1:0] cause;
    bit [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_edge  = 0;

  // Behavioural model: lock pipeline as a queue, phase + integer counters.
  int m_rs_edges;
  bit m_pipe[$];
  int m_phase;
  int m_filt;
  int m_held;
  int m_cause;
  int m_count;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void m_reset();
    m_rs_edges = 0;
    m_pipe.delete();
    repeat (SYNC_STAGES) m_pipe.push_back(1'b0);
    m_phase = PH_WAIT;
    m_filt  = 0;
    m_held  = 0;
    m_cause = 0;
    m_count = 0;
  endfunction

  function automatic void m_bump(input int cause);
    m_cause = cause;
    if (m_count < 255) m_count++;
  endfunction

  function automatic void m_edge(input bit pll, input bit sw, input bit rstn);
    bit   lock_s;
    exp_t e;
    if (!rstn) begin
      m_reset();
    end else if (m_rs_edges < 2) begin
      m_rs_edges++;
    end else begin
      lock_s = m_pipe[SYNC_STAGES-1];
      m_pipe.push_front(pll);
      void'(m_pipe.pop_back());
      if (m_phase == PH_WAIT) begin
        m_filt = lock_s ? m_filt + 1 : 0;
        if (m_filt == int'(LOCK_FILT)) begin
          m_phase = PH_HOLD;
          m_held  = 0;
        end
      end else if (!lock_s) begin
        m_phase = PH_WAIT;
        m_filt  = 0;
        m_bump(1);
      end else if (m_phase == PH_HOLD) begin
        m_held++;
        if (m_held == int'(HOLD_CYCLES)) m_phase = PH_RUN;
      end else if (sw) begin
        m_phase = PH_HOLD;
        m_held  = 0;
        m_bump(2);
      end
    end
    e.rstn  = (m_phase == PH_RUN);
    e.cause = m_cause[1:0];
    e.cnt   = m_count[7:0];
    sb.push_back(e);
  endfunction

  // Monitor: one expectation consumed per driven edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_rst_n_o", int'(rst_n_o), int'(e.rstn));
        check("sb_rst_cause_o", int'(rst_cause_o), int'(e.cause));
        check("sb_rst_cnt_o", int'(rst_cnt_o), int'(e.cnt));
      end
    end
  end

  task automatic step(input bit pll, input bit sw);
    @(negedge clk_i);
    pll_locked_i = pll;
    sw_rst_req_i = sw;
    m_edge(pll, sw, rst_n_i);
    @(posedge clk_i);
    #2;
    n_edge++;
  endtask

  // Asserts the pin with no clock edge, checks outputs at once, then releases.
  task automatic pin_reset(input string name, input bit pll);
    rst_n_i = 1'b0;
    #1;
    check({name, "_rst_n_o"}, int'(rst_n_o), 0);
    check({name, "_cause"}, int'(rst_cause_o), 0);
    check({name, "_cnt"}, int'(rst_cnt_o), 0);
    m_reset();
    repeat (3) step(pll, 1'b0);
    rst_n_i = 1'b1;
    n_edge  = 0;
  endtask

  // pll is high on edges after lock_from, except the single edge glitch_at.
  task automatic until_high(input int lock_from, input int glitch_at, input int limit,
                            output int steps);
    int k;
    steps = 0;
    while (rst_n_o !== 1'b1) begin
      if (steps >= limit) begin
        steps = -1;
        return;
      end
      k = n_edge + 1;
      step((k > lock_from) && (k != glitch_at), 1'b0);
      steps++;
    end
  endtask

  initial begin
    int steps;
    int lo_left;
    int sw_left;
    #1;

    // Power-up with lock steady high.
    pin_reset("init", 1'b1);
    until_high(0, 0, 300, steps);
    check("powerup_latency", steps, 2 + SYNC_STAGES + LOCK_FILT + HOLD_CYCLES);
    check("powerup_cause", int'(rst_cause_o), 0);
    check("powerup_cnt", int'(rst_cnt_o), 0);

    // Lock goes high just after edge 40, first sampled on edge 41.
    pin_reset("late", 1'b0);
    until_high(40, 0, 400, steps);
    check("late_lock_latency", steps, 40 + SYNC_STAGES + LOCK_FILT + HOLD_CYCLES);
    check("late_lock_cause", int'(rst_cause_o), 0);

    // Pin sampled low on edge 13 -> FSM sees lock_s low after 10 high cycles.
    pin_reset("glitch", 1'b1);
    until_high(0, 3 + 10, 400, steps);
    check("glitch_latency", steps, 2 + SYNC_STAGES + LOCK_FILT + HOLD_CYCLES + 11);

    // One-cycle software request from RUN.
    step(1'b1, 1'b1);
    check("sw_low_next_edge", int'(rst_n_o), 0);
    until_high(0, 0, 200, steps);
    check("sw_low_cycles", steps, HOLD_CYCLES);
    check("sw_cause", int'(rst_cause_o), 2);
    check("sw_cnt", int'(rst_cnt_o), 1);

    // Lock loss reaching the FSM on the same edge as a software request.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("lockloss_rst_n_o", int'(rst_n_o), 0);
    check("lockloss_cause", int'(rst_cause_o), 1);
    check("lockloss_cnt", int'(rst_cnt_o), 2);
    until_high(0, 0, 300, steps);
    check("relock_latency", steps, SYNC_STAGES + LOCK_FILT + HOLD_CYCLES);

    // Saturation of the reset counter.
    repeat (300) begin
      step(1'b1, 1'b1);
      until_high(0, 0, 200, steps);
      if (steps < 0) check("sat_relaunch_timeout", steps, HOLD_CYCLES);
    end
    check("sat_cnt", int'(rst_cnt_o), 255);
    check("sat_cause", int'(rst_cause_o), 2);

    // Pin reset mid-HOLD clears everything without a clock edge.
    step(1'b1, 1'b1);
    repeat (30) step(1'b1, 1'b0);
    pin_reset("async_midhold", 1'b1);
    until_high(0, 0, 300, steps);
    check("post_async_latency", steps, 2 + SYNC_STAGES + LOCK_FILT + HOLD_CYCLES);

    // Randomised lock drops and software requests, checked by the scoreboard.
    lo_left = 0;
    sw_left = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (i == 1500) pin_reset("rand_pin", 1'b1);
      if (lo_left == 0 && $urandom_range(0, 199) == 0) lo_left = int'($urandom_range(1, 24));
      if (sw_left == 0 && $urandom_range(0, 39) == 0) sw_left = int'($urandom_range(1, 3));
      step(lo_left == 0, sw_left != 0);
      if (lo_left > 0) lo_left--;
      if (sw_left > 0) sw_left--;
    end

    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
